// File: rtl/aes_pkg.sv
// Shared types for the AES round scheduler: one-hot FSM states, statemt-port owner codes, key_len->Nr table.
// Latency: none (types and pure functions only).
// Backpressure: not applicable.
package aes_pkg;

    typedef enum logic [7:0] {
        S_IDLE = 8'b0000_0001,
        S_ARK0 = 8'b0000_0010,
        S_SB   = 8'b0000_0100,
        S_MC   = 8'b0000_1000,
        S_ARK  = 8'b0001_0000,
        S_SBF  = 8'b0010_0000,
        S_ARKF = 8'b0100_0000,
        S_DONE = 8'b1000_0000
    } state_t;

    typedef enum logic [1:0] {
        SEL_ARK  = 2'd0,
        SEL_SB   = 2'd1,
        SEL_MC   = 2'd2,
        SEL_NONE = 2'd3
    } mem_sel_t;

    localparam logic [3:0] NR_RESET = 4'd10;

    // Round count for a key size; encoding 3 is reserved and falls back to dflt.
    function automatic logic [3:0] nr_of(input logic [1:0] kl, input logic [3:0] dflt);
        case (kl)
            2'd0:    return 4'd10;
            2'd1:    return 4'd12;
            2'd2:    return 4'd14;
            default: return dflt;
        endcase
    endfunction

    // Which child owns the statemt port while the FSM sits in state s.
    function automatic mem_sel_t sel_of(input state_t s);
        case (s)
            S_ARK0, S_ARK, S_ARKF: return SEL_ARK;
            S_SB, S_SBF:           return SEL_SB;
            S_MC:                  return SEL_MC;
            default:               return SEL_NONE;
        endcase
    endfunction

endpackage

// File: rtl/aes_phase_hs.sv
// Start/done handshake for one scheduler phase; masks a done seen in the phase's first cycle.
// Latency: combinational start/done_ok, one register tracks "past first cycle".
// Backpressure: start stays high until a qualified done; the phase owner holds active meanwhile.
module aes_phase_hs (
    input  logic clk,
    input  logic rst_n,
    input  logic active,
    input  logic done_in,
    output logic start,
    output logic done_ok
);

    logic armed;

    assign start   = active;
    assign done_ok = active && armed && done_in;

    // Armed from the second cycle of a phase; cleared whenever a phase ends so the next one starts masked.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            armed <= 1'b0;
        end else begin
            armed <= active && !done_ok;
        end
    end

endmodule

// File: rtl/aes_round_sched.sv
// Sequences AddRoundKey / ByteSub+ShiftRow / MixColumn children through a full AES block schedule.
// Latency: each phase costs child latency + 1 cycle, phases back-to-back, plus one DONE cycle.
// Backpressure: a phase holds its child start high until that child's done is accepted; other dones ignored.
module aes_round_sched
    import aes_pkg::*;
#(
    parameter int NR_DEFAULT = 10
) (
    input  logic        ap_clk,
    input  logic        ap_rst_n,
    input  logic        ap_start,
    input  logic [1:0]  key_len,
    output logic        ap_done,
    output logic        ap_idle,
    output logic        ap_ready,
    output logic        ark_start,
    input  logic        ark_done,
    output logic [31:0] ark_n,
    output logic        sb_start,
    input  logic        sb_done,
    output logic        mc_start,
    input  logic        mc_done,
    output logic [1:0]  mem_sel
);

    localparam logic [3:0] NR_DFLT = 4'(NR_DEFAULT);

    state_t     state, state_nxt;
    logic [3:0] rnd, rnd_nxt;
    logic [3:0] nr, nr_nxt;
    logic [4:0] rnd_inc;
    mem_sel_t   sel_q;
    logic [3:0] n_q, n_nxt;
    logic       in_phase;
    logic       child_done;
    logic       phase_start;
    logic       phase_go;

    aes_phase_hs u_hs (
        .clk     (ap_clk),
        .rst_n   (ap_rst_n),
        .active  (in_phase),
        .done_in (child_done),
        .start   (phase_start),
        .done_ok (phase_go)
    );

    assign ark_start = phase_start && (sel_q == SEL_ARK);
    assign sb_start  = phase_start && (sel_q == SEL_SB);
    assign mc_start  = phase_start && (sel_q == SEL_MC);
    assign mem_sel   = sel_q;
    assign ark_n     = {28'd0, n_q};
    assign ap_done   = (state == S_DONE);
    assign ap_ready  = (state == S_DONE);
    assign ap_idle   = (state == S_IDLE) && !ap_start;
    assign rnd_inc   = {1'b0, rnd} + 5'd1;

    // Only the done of the child owning the current phase reaches the handshake.
    always_comb begin
        child_done = 1'b0;
        case (sel_q)
            SEL_ARK: child_done = ark_done;
            SEL_SB:  child_done = sb_done;
            SEL_MC:  child_done = mc_done;
            default: child_done = 1'b0;
        endcase
    end

    // Next state, round counter and latched Nr; a phase advances only on a qualified done.
    always_comb begin
        state_nxt = state;
        rnd_nxt   = rnd;
        nr_nxt    = nr;
        in_phase  = 1'b0;
        case (state)
            S_IDLE: begin
                if (ap_start) begin
                    nr_nxt    = nr_of(key_len, NR_DFLT);
                    rnd_nxt   = 4'd0;
                    state_nxt = S_ARK0;
                end
            end
            S_ARK0: begin
                in_phase = 1'b1;
                if (phase_go) begin
                    rnd_nxt   = rnd_inc[3:0];
                    state_nxt = S_SB;
                end
            end
            S_SB: begin
                in_phase = 1'b1;
                if (phase_go) state_nxt = S_MC;
            end
            S_MC: begin
                in_phase = 1'b1;
                if (phase_go) state_nxt = S_ARK;
            end
            S_ARK: begin
                in_phase = 1'b1;
                if (phase_go) begin
                    rnd_nxt   = rnd_inc[3:0];
                    state_nxt = (rnd_inc < {1'b0, nr}) ? S_SB : S_SBF;
                end
            end
            S_SBF: begin
                in_phase = 1'b1;
                if (phase_go) state_nxt = S_ARKF;
            end
            S_ARKF: begin
                in_phase = 1'b1;
                if (phase_go) state_nxt = S_DONE;
            end
            S_DONE:  state_nxt = S_IDLE;
            default: state_nxt = S_IDLE;
        endcase
    end

    // Round index presented to AddRoundKey for the upcoming phase; zero outside ARK phases.
    always_comb begin
        n_nxt = 4'd0;
        case (state_nxt)
            S_ARK0, S_ARK: n_nxt = rnd_nxt;
            S_ARKF:        n_nxt = nr_nxt;
            default:       n_nxt = 4'd0;
        endcase
    end

    // State plus registered owner/round outputs, all loaded from next-state so they hold for a whole phase.
    always_ff @(posedge ap_clk) begin
        if (!ap_rst_n) begin
            state <= S_IDLE;
            rnd   <= 4'd0;
            nr    <= NR_RESET;
            sel_q <= SEL_NONE;
            n_q   <= 4'd0;
        end else begin
            state <= state_nxt;
            rnd   <= rnd_nxt;
            nr    <= nr_nxt;
            sel_q <= sel_of(state_nxt);
            n_q   <= n_nxt;
        end
    end

endmodule
